// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
// data_mem_responder: word memory behind a req/ready handshake with WAIT wait states; flags misaligned/out-of-range accesses
// Ports: clk, reset (async active-low); req/we/addr/wdata request side; ready/rdata/err one-cycle registered response; busy from acceptance through RESP.
module data_mem_responder #(
    parameter int n     = 16,
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         we,
    input  logic [n-1:0] addr,
    input  logic [n-1:0] wdata,
    output logic         ready,
    output logic [n-1:0] rdata,
    output logic         err,
    output logic         busy
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           we_q;
    logic [n-1:0]   addr_q, wdata_q;
    logic [n-1:0]   mem [DEPTH];
    logic           acc, go_resp, a_we, fault, commit;
    logic [n-1:0]   a_addr, a_wdata;
    logic [IW-1:0]  idx;
    assign acc     = (state_q != S_WAIT) && req;
    // with no wait states the access is performed on the acceptance edge itself, so use the live inputs
    assign go_resp = (WAIT == 0) ? acc : (state_q == S_WAIT && cnt_q == 4'd0);
    assign a_we    = (WAIT == 0) ? we    : we_q;
    assign a_addr  = (WAIT == 0) ? addr  : addr_q;
    assign a_wdata = (WAIT == 0) ? wdata : wdata_q;
    assign idx     = a_addr[IW:1];
    assign fault   = a_addr[0] || ({1'b0, a_addr[n-1:1]} >= n'(DEPTH));
    assign commit  = go_resp && a_we && !fault;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (go_resp) state_d = S_RESP;
        else if (acc) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT - 1);
        end
        else if (state_q == S_WAIT) cnt_d = cnt_q - 4'd1;
        else if (state_q == S_RESP) state_d = S_IDLE;
    end
    // memory array is deliberately left out of the reset branch so contents survive reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready   <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (acc) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (commit) mem[idx] <= a_wdata;
            ready <= go_resp;
            rdata <= (go_resp && !a_we && !fault) ? mem[idx] : '0;
            err   <= go_resp && fault;
            busy  <= state_d != S_IDLE;
        end
    end
endmodule
